// File: rtl/ps2_key_event_queue.sv
// PS/2 scan-code sequencer: folds E0/F0 prefixes into 10-bit key events
// and buffers them in a first-word-fall-through FIFO drained by a pop strobe.
module ps2_key_event_queue #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 100000
) (
    input  logic                     inclock,
    input  logic                     reset,
    input  logic [7:0]               ps2_key_data,
    input  logic                     ps2_received_data,
    input  logic                     rd_pop,
    input  logic                     clr_overflow,
    output logic                     event_valid,
    output logic [9:0]               event_data,
    output logic [$clog2(DEPTH):0]   event_count,
    output logic                     overflow
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned TmoW = $clog2(TIMEOUT);

    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);
    localparam logic [PtrW:0]   CntFull = (PtrW + 1)'(DEPTH);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StExt    = 2'd1;
    localparam logic [1:0] StBrk    = 2'd2;
    localparam logic [1:0] StExtBrk = 2'd3;

    localparam logic [7:0] ByteExt = 8'hE0;
    localparam logic [7:0] ByteBrk = 8'hF0;

    logic [1:0]      dec_q, dec_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            emit;
    logic [9:0]      emit_data;
    logic            is_filler;

    logic [9:0]      mem_q [DEPTH];
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [PtrW:0]   count_q;
    logic            ovf_q;
    logic            full, pop_ok, push_ok, ovf_set;

    // Bytes that carry no key information outside a prefix sequence.
    assign is_filler = ps2_key_data inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

    always_comb begin
        dec_d     = dec_q;
        tmo_d     = tmo_q;
        emit      = 1'b0;
        emit_data = '0;
        if (ps2_received_data) begin
            tmo_d = '0;
            case (dec_q)
                StIdle: begin
                    if (ps2_key_data == ByteExt) begin
                        dec_d = StExt;
                    end else if (ps2_key_data == ByteBrk) begin
                        dec_d = StBrk;
                    end else if (!is_filler) begin
                        emit      = 1'b1;
                        emit_data = {2'b00, ps2_key_data};
                    end
                end
                StExt: begin
                    if (ps2_key_data == ByteBrk) begin
                        dec_d = StExtBrk;
                    end else if (ps2_key_data != ByteExt) begin
                        emit      = 1'b1;
                        emit_data = {2'b01, ps2_key_data};
                        dec_d     = StIdle;
                    end
                end
                StBrk: begin
                    if (ps2_key_data == ByteExt) begin
                        dec_d = StExtBrk;
                    end else if (ps2_key_data != ByteBrk) begin
                        emit      = 1'b1;
                        emit_data = {2'b10, ps2_key_data};
                        dec_d     = StIdle;
                    end
                end
                default: begin
                    if (ps2_key_data != ByteExt && ps2_key_data != ByteBrk) begin
                        emit      = 1'b1;
                        emit_data = {2'b11, ps2_key_data};
                        dec_d     = StIdle;
                    end
                end
            endcase
        end else if (dec_q != StIdle) begin
            // An abandoned prefix silently returns to idle.
            if (tmo_q == TmoLast) begin
                dec_d = StIdle;
                tmo_d = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    assign full    = (count_q == CntFull);
    assign pop_ok  = rd_pop && (count_q != '0);
    assign push_ok = emit && (!full || pop_ok);
    assign ovf_set = emit && full && !pop_ok;

    always_ff @(posedge inclock) begin
        if (reset) begin
            dec_q   <= StIdle;
            tmo_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            dec_q <= dec_d;
            tmo_q <= tmo_d;
            if (push_ok) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop_ok) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - 1'b1;
            end
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (clr_overflow) begin
                ovf_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge inclock) begin
        if (push_ok) begin
            mem_q[wptr_q] <= emit_data;
        end
    end

    assign event_valid = (count_q != '0);
    assign event_data  = event_valid ? mem_q[rptr_q] : 10'h000;
    assign event_count = count_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Directed cycle table for the protocol corners, then randomized traffic
// checked against a queue-based reference model.
module tb_ps2_key_event_queue;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] kdata = 8'h00;
    logic       kstb = 1'b0;
    logic       pop = 1'b0;
    logic       clr = 1'b0;
    logic       event_valid;
    logic [9:0] event_data;
    logic [2:0] event_count;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    ps2_key_event_queue #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .inclock           (clk),
        .reset             (rst),
        .ps2_key_data      (kdata),
        .ps2_received_data (kstb),
        .rd_pop            (pop),
        .clr_overflow      (clr),
        .event_valid       (event_valid),
        .event_data        (event_data),
        .event_count       (event_count),
        .overflow          (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic       stb;
        logic [7:0] d;
        logic       pop;
        logic       clr;
        int         rep;
        logic       ev;
        logic [9:0] ed;
        logic [2:0] ec;
        logic       eo;
    } vec_t;

    vec_t tbl[$];

    // Reference model: pending-prefix flags, idle age and a plain queue.
    logic [9:0] mq[$];
    bit         m_pend, m_ext, m_brk, m_ovf;
    int         m_since;

    task automatic add(input string name, input logic r, input logic s, input logic [7:0] d,
                       input logic p, input logic c, input int rep, input logic ev,
                       input logic [9:0] ed, input logic [2:0] ec, input logic eo);
        vec_t v;
        v.name = name; v.rst = r; v.stb = s; v.d = d; v.pop = p; v.clr = c; v.rep = rep;
        v.ev = ev; v.ed = ed; v.ec = ec; v.eo = eo;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic r, input logic s, input logic [7:0] d, input logic p,
                         input logic c);
        rst = r; kstb = s; kdata = d; pop = p; clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic ev, input logic [9:0] ed,
                         input logic [2:0] ec, input logic eo);
        checks++;
        if (event_valid !== ev || event_data !== ed || event_count !== ec || overflow !== eo)
        begin
            errors++;
            $display("FAIL %s: got valid=%0b data=%03h count=%0d ovf=%0b, want valid=%0b data=%03h count=%0d ovf=%0b",
                     name, event_valid, event_data, event_count, overflow, ev, ed, ec, eo);
        end
    endtask

    function automatic bit filler(input logic [7:0] b);
        return (b == 8'h00 || b == 8'hAA || b == 8'hEE || b == 8'hFA || b == 8'hFE ||
                b == 8'hFF);
    endfunction

    function automatic logic [7:0] filler_byte(input int i);
        case (i)
            0: return 8'h00;
            1: return 8'hAA;
            2: return 8'hEE;
            3: return 8'hFA;
            4: return 8'hFE;
            default: return 8'hFF;
        endcase
    endfunction

    task automatic model_step(input logic r, input logic s, input logic [7:0] d, input logic p,
                              input logic c);
        bit         emit;
        logic [9:0] ev;
        emit = 0;
        ev   = '0;
        if (r) begin
            mq.delete();
            m_pend = 0; m_ext = 0; m_brk = 0; m_ovf = 0; m_since = 0;
            return;
        end
        if (s) begin
            if (!m_pend) begin
                if (d == 8'hE0) begin
                    m_pend = 1; m_ext = 1; m_brk = 0;
                end else if (d == 8'hF0) begin
                    m_pend = 1; m_ext = 0; m_brk = 1;
                end else if (!filler(d)) begin
                    emit = 1; ev = {2'b00, d};
                end
            end else if (d == 8'hE0) begin
                m_ext = 1;
            end else if (d == 8'hF0) begin
                m_brk = 1;
            end else begin
                emit = 1; ev = {m_brk, m_ext, d}; m_pend = 0;
            end
            m_since = 0;
        end else if (m_pend) begin
            m_since++;
            if (m_since == int'(TIMEOUT)) m_pend = 0;
        end
        if (p && mq.size() > 0) void'(mq.pop_front());
        if (emit && mq.size() >= int'(DEPTH)) begin
            m_ovf = 1;
        end else begin
            if (emit) mq.push_back(ev);
            if (c) m_ovf = 0;
        end
    endtask

    initial begin
        int         gap;
        logic       r, s, p, c;
        logic [7:0] d;
        logic [9:0] hd;

        //   name              rst stb data   pop clr rep  ev  data     cnt eo
        add("reset",           1, 0, 8'h00, 0, 0, 1,  0, 10'h000, 0, 0);
        add("make_1c",         0, 1, 8'h1C, 0, 0, 1,  1, 10'h01C, 1, 0);
        add("pop_1c",          0, 0, 8'h00, 1, 0, 1,  0, 10'h000, 0, 0);
        add("eb_e0",           0, 1, 8'hE0, 0, 0, 1,  0, 10'h000, 0, 0);
        add("eb_f0",           0, 1, 8'hF0, 0, 0, 1,  0, 10'h000, 0, 0);
        add("eb_75",           0, 1, 8'h75, 0, 0, 1,  1, 10'h375, 1, 0);
        add("pop_eb",          0, 0, 8'h00, 1, 0, 1,  0, 10'h000, 0, 0);
        add("brk_f0",          0, 1, 8'hF0, 0, 0, 1,  0, 10'h000, 0, 0);
        add("brk_1c",          0, 1, 8'h1C, 0, 0, 1,  1, 10'h21C, 1, 0);
        add("pop_brk",         0, 0, 8'h00, 1, 0, 1,  0, 10'h000, 0, 0);
        add("ext_e0",          0, 1, 8'hE0, 0, 0, 1,  0, 10'h000, 0, 0);
        add("ext_75",          0, 1, 8'h75, 0, 0, 1,  1, 10'h175, 1, 0);
        add("pop_ext",         0, 0, 8'h00, 1, 0, 1,  0, 10'h000, 0, 0);
        add("fill_fa",         0, 1, 8'hFA, 0, 0, 1,  0, 10'h000, 0, 0);
        add("fill_aa",         0, 1, 8'hAA, 0, 0, 1,  0, 10'h000, 0, 0);
        add("pfx_fa_e0",       0, 1, 8'hE0, 0, 0, 1,  0, 10'h000, 0, 0);
        add("pfx_fa",          0, 1, 8'hFA, 0, 0, 1,  1, 10'h1FA, 1, 0);
        add("pop_pfx_fa",      0, 0, 8'h00, 1, 0, 1,  0, 10'h000, 0, 0);
        add("to_e0",           0, 1, 8'hE0, 0, 0, 1,  0, 10'h000, 0, 0);
        add("to_idle",         0, 0, 8'h00, 0, 0, 10, 0, 10'h000, 0, 0);
        add("to_1c",           0, 1, 8'h1C, 0, 0, 1,  1, 10'h01C, 1, 0);
        add("pop_to",          0, 0, 8'h00, 1, 0, 1,  0, 10'h000, 0, 0);
        add("ok_e0",           0, 1, 8'hE0, 0, 0, 1,  0, 10'h000, 0, 0);
        add("ok_idle",         0, 0, 8'h00, 0, 0, 5,  0, 10'h000, 0, 0);
        add("ok_1c",           0, 1, 8'h1C, 0, 0, 1,  1, 10'h11C, 1, 0);
        add("pop_ok",          0, 0, 8'h00, 1, 0, 1,  0, 10'h000, 0, 0);
        add("edge_e0",         0, 1, 8'hE0, 0, 0, 1,  0, 10'h000, 0, 0);
        add("edge_idle",       0, 0, 8'h00, 0, 0, 7,  0, 10'h000, 0, 0);
        add("edge_1c",         0, 1, 8'h1C, 0, 0, 1,  1, 10'h11C, 1, 0);
        add("pop_edge",        0, 0, 8'h00, 1, 0, 1,  0, 10'h000, 0, 0);
        add("late_e0",         0, 1, 8'hE0, 0, 0, 1,  0, 10'h000, 0, 0);
        add("late_idle",       0, 0, 8'h00, 0, 0, 8,  0, 10'h000, 0, 0);
        add("late_1c",         0, 1, 8'h1C, 0, 0, 1,  1, 10'h01C, 1, 0);
        add("pop_late",        0, 0, 8'h00, 1, 0, 1,  0, 10'h000, 0, 0);
        add("fill_1",          0, 1, 8'h1C, 0, 0, 1,  1, 10'h01C, 1, 0);
        add("fill_2",          0, 1, 8'h1D, 0, 0, 1,  1, 10'h01C, 2, 0);
        add("fill_3",          0, 1, 8'h1E, 0, 0, 1,  1, 10'h01C, 3, 0);
        add("fill_4",          0, 1, 8'h1F, 0, 0, 1,  1, 10'h01C, 4, 0);
        add("drop_5",          0, 1, 8'h20, 0, 0, 1,  1, 10'h01C, 4, 1);
        add("set_beats_clr",   0, 1, 8'h22, 0, 1, 1,  1, 10'h01C, 4, 1);
        add("clr_ovf",         0, 0, 8'h00, 0, 1, 1,  1, 10'h01C, 4, 0);
        add("full_push_pop",   0, 1, 8'h21, 1, 0, 1,  1, 10'h01D, 4, 0);
        add("drain_1",         0, 0, 8'h00, 1, 0, 1,  1, 10'h01E, 3, 0);
        add("drain_2",         0, 0, 8'h00, 1, 0, 1,  1, 10'h01F, 2, 0);
        add("drain_3",         0, 0, 8'h00, 1, 0, 1,  1, 10'h021, 1, 0);
        add("drain_4",         0, 0, 8'h00, 1, 0, 1,  0, 10'h000, 0, 0);
        add("pop_empty",       0, 0, 8'h00, 1, 0, 1,  0, 10'h000, 0, 0);
        add("q_30",            0, 1, 8'h30, 0, 0, 1,  1, 10'h030, 1, 0);
        add("q_31",            0, 1, 8'h31, 0, 0, 1,  1, 10'h030, 2, 0);
        add("q_e0",            0, 1, 8'hE0, 0, 0, 1,  1, 10'h030, 2, 0);
        add("mid_reset",       1, 0, 8'h00, 0, 0, 1,  0, 10'h000, 0, 0);
        add("post_rst_1c",     0, 1, 8'h1C, 0, 0, 1,  1, 10'h01C, 1, 0);
        add("pop_post_rst",    0, 0, 8'h00, 1, 0, 1,  0, 10'h000, 0, 0);
        add("push_pop_empty",  0, 1, 8'h40, 1, 0, 1,  1, 10'h040, 1, 0);
        add("pop_40",          0, 0, 8'h00, 1, 0, 1,  0, 10'h000, 0, 0);

        drive(1, 0, 8'h00, 0, 0);
        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].rep; k++) begin
                drive(tbl[i].rst, tbl[i].stb, tbl[i].d, tbl[i].pop, tbl[i].clr);
                check(tbl[i].name, tbl[i].ev, tbl[i].ed, tbl[i].ec, tbl[i].eo);
            end
        end

        drive(1, 0, 8'h00, 0, 0);
        model_step(1, 0, 8'h00, 0, 0);
        gap = 0;
        for (int n = 0; n < 4000; n++) begin
            r = ($urandom_range(0, 499) == 0);
            p = ($urandom_range(0, 3) == 0);
            c = ($urandom_range(0, 19) == 0);
            if (gap > 0) begin
                s = 1'b0;
                gap--;
            end else begin
                s = ($urandom_range(0, 9) < 5);
                if ($urandom_range(0, 19) == 0) gap = $urandom_range(5, 11);
            end
            case ($urandom_range(0, 7))
                0:       d = 8'hE0;
                1:       d = 8'hF0;
                2:       d = filler_byte($urandom_range(0, 5));
                default: d = 8'($urandom);
            endcase
            drive(r, s, d, p, c);
            model_step(r, s, d, p, c);
            hd = (mq.size() > 0) ? mq[0] : 10'h000;
            check("random", mq.size() > 0, hd, 3'(mq.size()), m_ovf);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_key_event_queue.md
# ps2_key_event_queue

Turns the raw byte stream from the PS/2 interface (8-bit byte plus one-cycle received strobe) into complete key events and queues them for the processor. Sequences the multi-byte scan-code protocol (E0 extended prefix, F0 break prefix). Buffers events in a small first-word-fall-through FIFO. The CPU drains the FIFO through a pop-strobe handshake. Sits between the PS/2 interface and the memory-mapped I/O decode.

## Interface

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64
- TIMEOUT, 100000, cycles allowed between a prefix byte and its completing byte (2 ms at 50 MHz); minimum 4

Ports:
- inclock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- ps2_key_data  in  8  byte from PS/2 interface; valid only when ps2_received_data=1
- ps2_received_data  in  1  one-cycle strobe per received byte
- rd_pop  in  1  CPU pop request; one-cycle pulse, consumes head entry
- clr_overflow  in  1  clears the overflow flag
- event_valid  out  1  FIFO non-empty
- event_data  out  10  head entry {release, extended, code[7:0]}; 0 when empty
- event_count  out  clog2(DEPTH)+1  number of queued entries
- overflow  out  1  sticky; set when an event was dropped because the FIFO was full

## Operation

Decoder state machine (DEC):
- States: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
- Acts only on cycles with ps2_received_data=1.
- IDLE: E0 goes to EXT; F0 goes to BRK.
  - Filler bytes 00, AA, EE, FA, FE and FF are discarded; state stays IDLE.
  - Any other byte emits {0,0,byte}; state stays IDLE.
- EXT: F0 goes to EXT_BRK; a repeated E0 stays in EXT.
  - Any other byte emits {0,1,byte}; state goes to IDLE.
- BRK: a repeated F0 stays in BRK; E0 goes to EXT_BRK.
  - Any other byte emits {1,0,byte}; state goes to IDLE.
- EXT_BRK: E0 and F0 stay in EXT_BRK.
  - Any other byte emits {1,1,byte}; state goes to IDLE.
- Filler bytes are discarded only in IDLE. In the prefix states they complete an event like any other byte.

Prefix timeout:
- A counter clears on every strobe.
- It increments every cycle while DEC is not IDLE.
- When it reaches TIMEOUT-1 with no strobe in that cycle, DEC returns to IDLE. No event is emitted.
- A strobe in the same cycle as expiry wins: the byte is decoded normally.

FIFO:
- Circular buffer with read and write pointers that wrap modulo DEPTH.
- An emitted event is a push.
- Push when not full: entry written, count increments.
- Push when full and no pop in the same cycle: event dropped, overflow set to 1, FIFO unchanged.
- Push and pop in the same cycle while full: both succeed, count unchanged, no overflow.
- Pop when empty: ignored. A simultaneous push still writes.
- event_data is combinationally the head entry when count is greater than 0, else 0.

Overflow flag:
- Set has priority over clr_overflow in the same cycle.

## Timing

- Reset values:
  - DEC = IDLE, timeout counter = 0, pointers = 0.
  - event_count = 0, event_valid = 0, event_data = 0, overflow = 0.
- Reset mid-sequence discards any pending prefix and all queued entries.
- Latency: a completing strobe in cycle N gives event_valid=1 and event_data updated in cycle N+1.
- rd_pop in cycle N updates the head and count in cycle N+1.
- Back-to-back strobes on consecutive cycles are accepted; there is no backpressure toward PS/2.
- event_count is registered and equals write count minus read count, 0..DEPTH.

## Test plan

- Reset, then byte 1C → cycle after the strobe: event_valid=1, event_data=0x01C, event_count=1. Then rd_pop → event_valid=0, event_data=0.
- Sequence E0 F0 75 → exactly one entry, 0x375. Sequence F0 1C → 0x21C. Sequence E0 75 → 0x175. Filler bytes FA and AA in IDLE → no entries.
- With TIMEOUT=8: send E0, idle 10 cycles, then 1C → entry 0x01C, not 0x11C. Repeat with 1C sent 6 cycles after E0 → 0x11C.
- DEPTH=4: push 5 single-byte events without popping → count=4, overflow=1, entries are the first four in order. clr_overflow → overflow=0.
- With the FIFO full, assert rd_pop in the same cycle as a completing strobe → count stays 4, overflow stays 0, new entry is at the tail.
- Assert reset after E0 while 2 entries are queued → count=0, event_valid=0. A following 1C yields 0x01C.
